// File: rtl/mem_writer.sv
// mem_writer: sequences single-byte writes and reads to a 4-byte store/addy memory.
// Latency: write 4 cycles acceptance-to-ready, read data/rd_done 2 cycles after request.
// Backpressure: wr_ready low outside ready-IDLE; requests seen then are dropped. Option: MEM_WRITER_SCAN_EN.
module mem_writer #(
   parameter int SCAN_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [7:0] wr_data,
   input  logic [1:0] wr_addr,
   input  logic       auto_inc,
   input  logic       rd_valid,
   input  logic [1:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       rd_done,
   input  logic [7:0] mem_q,
   output logic [7:0] mem_data,
   output logic       mem_store,
   output logic [1:0] mem_addy,
   output logic [1:0] ptr
);

   typedef enum logic [2:0] {IDLE, SETUP, STORE, HOLD, RSETTLE, RCAPT} state_t;

   state_t     state, state_nxt;
   logic       wr_ready_nxt;
   logic       mem_store_nxt;
   logic       rd_done_nxt;
   logic [7:0] mem_data_nxt;
   logic [7:0] rd_data_nxt;
   logic [1:0] mem_addy_nxt;
   logic [1:0] ptr_nxt;
   logic       inc, inc_nxt;
`ifdef MEM_WRITER_SCAN_EN
   logic [7:0] div, div_nxt;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_nxt     = state;
      mem_data_nxt  = mem_data;
      mem_addy_nxt  = mem_addy;
      ptr_nxt       = ptr;
      inc_nxt       = inc;
      rd_data_nxt   = rd_data;
      mem_store_nxt = 1'b0;
      rd_done_nxt   = 1'b0;
`ifdef MEM_WRITER_SCAN_EN
      div_nxt       = div;
`endif
      case (state)
         IDLE: begin
            // wr_ready gates both request types, so a write always beats a read.
            if (wr_ready && wr_valid) begin
               state_nxt    = SETUP;
               mem_data_nxt = wr_data;
               mem_addy_nxt = auto_inc ? ptr : wr_addr;
               inc_nxt      = auto_inc;
            end else if (wr_ready && rd_valid) begin
               state_nxt    = RSETTLE;
               mem_addy_nxt = rd_addr;
            end else begin
`ifdef MEM_WRITER_SCAN_EN
               if (div == 8'(SCAN_DIV - 1)) begin
                  div_nxt      = 8'd0;
                  mem_addy_nxt = mem_addy + 2'd1;
               end else begin
                  div_nxt      = div + 8'd1;
               end
`endif
            end
         end
         SETUP: begin
            state_nxt     = STORE;
            mem_store_nxt = 1'b1;
         end
         STORE: state_nxt = HOLD;
         HOLD: begin
            state_nxt = IDLE;
            if (inc) ptr_nxt = ptr + 2'd1;
`ifdef MEM_WRITER_SCAN_EN
            mem_addy_nxt = 2'd0;
            div_nxt      = 8'd0;
`endif
         end
         RSETTLE: state_nxt = RCAPT;
         RCAPT: begin
            state_nxt   = IDLE;
            rd_data_nxt = mem_q;
            rd_done_nxt = 1'b1;
`ifdef MEM_WRITER_SCAN_EN
            mem_addy_nxt = 2'd0;
            div_nxt      = 8'd0;
`endif
         end
         default: state_nxt = IDLE;
      endcase
      // Ready only after a full cycle spent in IDLE; this also gives the
      // first-edge-after-reset rise since reset parks the FSM in IDLE.
      wr_ready_nxt = (state == IDLE) && (state_nxt == IDLE);
   end

   // Output and datapath registers; reset aborts any transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ready  <= 1'b0;
         mem_store <= 1'b0;
         mem_data  <= 8'd0;
         mem_addy  <= 2'd0;
         ptr       <= 2'd0;
         inc       <= 1'b0;
         rd_data   <= 8'd0;
         rd_done   <= 1'b0;
`ifdef MEM_WRITER_SCAN_EN
         div       <= 8'd0;
`endif
      end else begin
         wr_ready  <= wr_ready_nxt;
         mem_store <= mem_store_nxt;
         mem_data  <= mem_data_nxt;
         mem_addy  <= mem_addy_nxt;
         ptr       <= ptr_nxt;
         inc       <= inc_nxt;
         rd_data   <= rd_data_nxt;
         rd_done   <= rd_done_nxt;
`ifdef MEM_WRITER_SCAN_EN
         div       <= div_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_mem_writer.sv
// Bench for mem_writer: directed literal checks plus randomized traffic
// compared every cycle against a transaction-age reference model.
// Attached 4-byte memory: combinational read, store on rising edge.
module tb_mem_writer;
   localparam int SCAN_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'd0;
   logic [1:0] wr_addr = 2'd0;
   logic       auto_inc = 1'b0;
   logic       rd_valid = 1'b0;
   logic [1:0] rd_addr = 2'd0;
   logic       wr_ready, rd_done, mem_store;
   logic [7:0] rd_data, mem_data, mem_q;
   logic [1:0] mem_addy, ptr;

   logic [7:0] mem [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

   int n_cmp = 0;
   int n_fail = 0;
   bit started = 1'b0;

   mem_writer #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .wr_addr(wr_addr), .auto_inc(auto_inc),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
      .mem_q(mem_q), .mem_data(mem_data), .mem_store(mem_store),
      .mem_addy(mem_addy), .ptr(ptr)
   );

   always #5 clk = ~clk;

   assign mem_q = mem[mem_addy];
   always @(posedge clk) if (mem_store) mem[mem_addy] <= mem_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_op: 0 idle, 1 write, 2 read; m_age counts edges since acceptance.
   int         m_op = 0, m_age = 0, m_div = 0;
   bit         m_inc = 1'b0;
   logic [1:0] m_raddr = 2'd0;
   logic [7:0] m_mem [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
   bit         e_ready = 1'b0, e_store = 1'b0, e_done = 1'b0;
   logic [7:0] e_data = 8'd0, e_rd = 8'd0;
   logic [1:0] e_addy = 2'd0, e_ptr = 2'd0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_op = 0; m_age = 0; m_div = 0;
         e_ready = 0; e_store = 0; e_done = 0;
         e_data = 0; e_rd = 0; e_addy = 0; e_ptr = 0;
      end else begin
         e_store = 0;
         e_done  = 0;
         if (m_op == 1 && m_age < 3) begin
            m_age++;
            e_store = (m_age == 1);
            if (m_age == 2) m_mem[e_addy] = e_data;
            if (m_age == 3) begin
               if (m_inc) e_ptr = 2'((int'(e_ptr) + 1) % 4);
`ifdef MEM_WRITER_SCAN_EN
               e_addy = 0; m_div = 0;
`endif
            end
         end else if (m_op == 2 && m_age < 2) begin
            m_age++;
            if (m_age == 2) begin
               e_rd = m_mem[m_raddr];
               e_done = 1;
`ifdef MEM_WRITER_SCAN_EN
               e_addy = 0; m_div = 0;
`endif
            end
         end else if (e_ready && wr_valid) begin
            m_op = 1; m_age = 0; e_ready = 0;
            e_data = wr_data;
            e_addy = auto_inc ? e_ptr : wr_addr;
            m_inc = auto_inc;
         end else if (e_ready && rd_valid) begin
            m_op = 2; m_age = 0; e_ready = 0;
            e_addy = rd_addr; m_raddr = rd_addr;
         end else begin
            m_op = 0; e_ready = 1;
`ifdef MEM_WRITER_SCAN_EN
            m_div++;
            if (m_div == SCAN_DIV) begin
               m_div = 0;
               e_addy = 2'((int'(e_addy) + 1) % 4);
            end
`endif
         end
      end
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (rst_n && started) begin
         chk("wr_ready",  wr_ready,  e_ready);
         chk("mem_store", mem_store, e_store);
         chk("mem_data",  mem_data,  e_data);
         chk("mem_addy",  mem_addy,  e_addy);
         chk("ptr",       ptr,       e_ptr);
         chk("rd_data",   rd_data,   e_rd);
         chk("rd_done",   rd_done,   e_done);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_ready();
      int n = 0;
      while (!wr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!wr_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ready_timeout: wr_ready got 0 expected 1 at %0t", $time);
      end
   endtask

   task automatic do_write(input logic [7:0] d, input logic [1:0] a, input logic inc);
      wait_ready();
      wr_valid = 1; wr_data = d; wr_addr = a; auto_inc = inc;
      @(negedge clk);
      wr_valid = 0;
   endtask

   initial #200000 begin
      $display("FAIL watchdog: simulation still running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_wr_ready",  wr_ready,  0);
      chk("rst_mem_store", mem_store, 0);
      chk("rst_mem_data",  mem_data,  0);
      chk("rst_mem_addy",  mem_addy,  0);
      chk("rst_ptr",       ptr,       0);
      chk("rst_rd_data",   rd_data,   0);
      chk("rst_rd_done",   rd_done,   0);
      @(negedge clk);
      rst_n = 1; started = 1;
      @(negedge clk);
      chk("ready_first_edge", wr_ready, 1);

`ifndef MEM_WRITER_SCAN_EN
      repeat (16) begin
         @(negedge clk);
         chk("idle_addy_const", mem_addy, 0);
      end
`endif

      // Single direct write 0xA5 to address 2.
      wait_ready();
      wr_valid = 1; wr_data = 8'hA5; wr_addr = 2; auto_inc = 0;
      @(negedge clk);
      wr_valid = 0;
      chk("w_setup_addy", mem_addy, 2);
      chk("w_setup_data", mem_data, 8'hA5);
      chk("w_setup_store", mem_store, 0);
      chk("w_setup_ready", wr_ready, 0);
      @(negedge clk);
      chk("w_store_store", mem_store, 1);
      chk("w_store_addy", mem_addy, 2);
      @(negedge clk);
      chk("w_hold_store", mem_store, 0);
      chk("w_hold_data", mem_data, 8'hA5);
      @(negedge clk);
      chk("w_lat3_ready", wr_ready, 0);
      @(negedge clk);
      chk("w_lat4_ready", wr_ready, 1);

      // Four auto-increment writes: addresses 0..3, pointer wraps.
      for (int i = 0; i < 4; i++) begin
         do_write(8'(17 * (i + 1)), 2'd0, 1'b1);
         @(negedge clk);
         chk("ai_store", mem_store, 1);
         chk("ai_addy", mem_addy, i);
      end
      wait_ready();
      chk("ai_ptr_wrap", ptr, 0);

      // Read address 2 back.
      rd_valid = 1; rd_addr = 2;
      @(negedge clk);
      rd_valid = 0;
      chk("rd_c1_done", rd_done, 0);
      @(negedge clk);
      chk("rd_c2_done", rd_done, 0);
      @(negedge clk);
      chk("rd_c3_done", rd_done, 1);
      chk("rd_c3_data", rd_data, 8'h33);
      @(negedge clk);
      chk("rd_c4_done", rd_done, 0);

      // Simultaneous write and read: write wins, read dropped.
      wait_ready();
      wr_valid = 1; wr_data = 8'h5A; wr_addr = 1; auto_inc = 0;
      rd_valid = 1; rd_addr = 3;
      @(negedge clk);
      wr_valid = 0; rd_valid = 0;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (rd_done) cnt++;
      end
      chk("both_no_rd_done", cnt, 0);
      chk("both_rd_data", rd_data, 8'h33);
      chk("both_mem_written", mem[1], 8'h5A);

      // Reset during STORE aborts the write.
      do_write(8'hC3, 2'd0, 1'b1);
      @(negedge clk);
      chk("ab_in_store", mem_store, 1);
      #2 rst_n = 0;
      #1;
      chk("ab_store_low", mem_store, 0);
      chk("ab_ptr", ptr, 0);
      chk("ab_ready", wr_ready, 0);
      @(negedge clk);
      chk("ab_ready_held", wr_ready, 0);
      rst_n = 1;
      @(negedge clk);
      chk("ab_ready_rise", wr_ready, 1);
      chk("ab_mem_untouched", mem[0], 8'h11);

      // Randomized traffic, including requests while busy.
      repeat (600) begin
         @(negedge clk);
         wr_valid = ($urandom_range(0, 2) == 0);
         rd_valid = ($urandom_range(0, 2) == 0);
         wr_data  = 8'($urandom);
         wr_addr  = 2'($urandom);
         rd_addr  = 2'($urandom);
         auto_inc = 1'($urandom);
      end
      @(negedge clk);
      wr_valid = 0; rd_valid = 0;
      repeat (10) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_writer.md
MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4, meaning clock cycles per address step in scan mode (legal values 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port wr_valid, input, 1 bit: write request.
REQ-005 The block SHALL have port wr_ready, output, 1 bit: write request can be accepted.
REQ-006 The block SHALL have port wr_data, input, 8 bits: byte to store.
REQ-007 The block SHALL have port wr_addr, input, 2 bits: target byte when auto_inc=0.
REQ-008 The block SHALL have port auto_inc, input, 1 bit: use the internal pointer instead of wr_addr.
REQ-009 The block SHALL have port rd_valid, input, 1 bit: read request for rd_addr.
REQ-010 The block SHALL have port rd_addr, input, 2 bits: byte to read.
REQ-011 The block SHALL have port rd_data, output, 8 bits: captured read byte.
REQ-012 The block SHALL have port rd_done, output, 1 bit: one-cycle pulse when rd_data is updated.
REQ-013 The block SHALL have port mem_q, input, 8 bits: mem output of the downstream 4-byte memory.
REQ-014 The block SHALL have ports mem_data (output, 8 bits), mem_store (output, 1 bit) and mem_addy (output, 2 bits), driving the memory's in, store and addy inputs.
REQ-015 The block SHALL have port ptr, output, 2 bits: current auto-increment pointer.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, STORE, HOLD, RSETTLE and RCAPT, with all outputs registered.
REQ-017 wr_ready SHALL be 1 only in IDLE; a write is accepted on a clock edge where wr_valid=1 and wr_ready=1.
REQ-018 On acceptance, the block SHALL latch mem_data=wr_data and mem_addy=(auto_inc ? ptr : wr_addr), then go to SETUP.
REQ-019 The write sequence SHALL be SETUP -> STORE -> HOLD -> IDLE, one cycle each; mem_store=1 only in STORE; mem_data and mem_addy SHALL stay stable across SETUP, STORE and HOLD.
REQ-020 Write latency SHALL be 4 cycles from the acceptance edge to wr_ready=1 again.
REQ-021 ptr SHALL increment modulo 4 (3 -> 0) on leaving HOLD only when the accepted write used auto_inc=1.
REQ-022 In IDLE with rd_valid=1 and no write, the block SHALL set mem_addy=rd_addr and go to RSETTLE, then to RCAPT, where rd_data is loaded from mem_q and rd_done pulses for 1 cycle, then return to IDLE.
REQ-023 When wr_valid and rd_valid are both 1 in IDLE, the write SHALL win and the read SHALL be ignored; rd_valid is not queued.
REQ-024 wr_valid and rd_valid outside IDLE SHALL have no effect.
REQ-025 rd_data SHALL hold its value until the next RCAPT.

Reset
REQ-026 While rst_n=0, the block SHALL force state IDLE, wr_ready=0, mem_store=0, mem_data=0, mem_addy=0, ptr=0, rd_data=0 and rd_done=0, immediately and without a clock.
REQ-027 wr_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-028 A reset during any write or read SHALL abort it: no store pulse completes, the write is not retried, and ptr is not incremented.

Configuration
REQ-029 With macro MEM_WRITER_SCAN_EN defined, the block SHALL, while in IDLE with no request, step mem_addy 0 -> 1 -> 2 -> 3 -> 0 every SCAN_DIV cycles using an internal divider counter reset to 0.
REQ-030 In scan mode, a request SHALL override mem_addy on acceptance; scan SHALL resume from address 0 with the divider cleared on return to IDLE.
REQ-031 Without MEM_WRITER_SCAN_EN, mem_addy SHALL hold its last value in IDLE and no divider logic SHALL exist.

Verification
REQ-032 Reset, then wr_valid=1, wr_data=0xA5, wr_addr=2, auto_inc=0 -> mem_addy=2 and mem_data=0xA5 for 3 cycles, mem_store=1 exactly in the 2nd, wr_ready=1 again 4 cycles after acceptance.
REQ-033 Four auto_inc writes 0x11, 0x22, 0x33, 0x44 from reset -> mem_addy sequence 0, 1, 2, 3; ptr ends at 0 (wrap).
REQ-034 After REQ-033, rd_valid=1, rd_addr=2, with a memory model -> rd_data=0x33 and a single rd_done pulse 2 cycles after the request edge.
REQ-035 wr_valid=1 and rd_valid=1 in the same IDLE cycle -> write performed, no rd_done, rd_data unchanged.
REQ-036 rst_n=0 asserted during STORE -> mem_store=0 immediately, ptr unchanged, wr_ready=0 until the first edge after release.
REQ-037 With MEM_WRITER_SCAN_EN and SCAN_DIV=4, idle for 16 cycles -> mem_addy steps 0, 1, 2, 3, each held 4 cycles; without the macro, mem_addy stays constant.
